serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the combinational half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, using a single full-adder cell.
- Sits as a small-area arithmetic unit behind a start/busy/done handshake, for datapaths where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse when sum/cout become valid
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  final carry-out; held alongside sum

Behaviour:
- Reset (async assert, any time): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flop and bit counter cleared. An in-flight operation is discarded, with no done pulse. Deassertion is synchronous to clk by system convention.
- States:
  - IDLE: busy=0. A clock edge with start=1 is an accepted start. It loads a/b into shift registers, loads the carry flop with cin, clears the counter and sum register, and moves to RUN.
  - RUN: busy=1. Each edge:
    - full-adder cell takes the current LSBs of A/B and the carry flop;
    - sum bit shifts into sum from the MSB end;
    - A/B shift right, carry flop updates, counter increments.
    - When counter reaches WIDTH-1 on an edge, move to FIN.
  - FIN: busy=0, done=1 for exactly one cycle. cout = carry flop. Returns to IDLE next edge. start=1 in FIN is accepted exactly as in IDLE, enabling back-to-back operations with zero bubble.
- Latency: start accepted at edge k. RUN spans edges k+1..k+WIDTH. done is high in the cycle after edge k+WIDTH. Total WIDTH+1 cycles start-to-done.
- start while busy=1 is ignored, and a/b/cin may change freely.
- sum and cout change only on reset, on an accepted start (sum cleared), during RUN shifting, and at the transition to FIN. Consumers read them only on done=1 or afterwards.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- WIDTH=1: one RUN cycle, done two cycles after start.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - When sub=1: B is bit-inverted at load and the carry flop loads 1 (cin ignored), so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a >= b unsigned).
- Not defined:
  - Port absent; addition only, exactly as above.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding typedef adder_state_t {IDLE, RUN, FIN};
  - default width constant ADDER_WIDTH_DEF=8.
- One natural sub-module: full_adder_cell (a, b, cin -> s, cout), purely combinational, instantiated once. It reuses the team's half-adder pair structure.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0, start one cycle -> busy high 8 cycles, done pulse at cycle 9, sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start accepted, then start pulsed with new operands mid-RUN -> ignored; original result delivered, one done pulse only.
- start held high through FIN -> second op accepted in the done cycle; busy reasserts the next cycle; both results correct; two done pulses exactly WIDTH+1 cycles apart.
- rst asserted asynchronously at RUN cycle 4 -> outputs zero immediately, no done pulse. A fresh op 0x12+0x34 after release gives sum=0x46.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0. Then a=0x07, b=0x05 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
// Shared declarations for the small arithmetic units.
//   adder_state_t   : control state of the bit-serial adder (IDLE/RUN/FIN)
//   ADDER_WIDTH_DEF : default operand width of serial_adder
// ----------------------------------------------------------------------------
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } adder_state_t;

   localparam int ADDER_WIDTH_DEF = 8;

endpackage : arith_pkg

// File: rtl/full_adder_cell.sv
// ----------------------------------------------------------------------------
// full_adder_cell
// Purely combinational one-bit full adder built as two cascaded half adders
// whose carries are ORed together.
// Ports:
//   a, b  (in)  : operand bits
//   cin   (in)  : carry in
//   s     (out) : sum bit
//   cout  (out) : carry out
// ----------------------------------------------------------------------------
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_hs1_s;
   logic w_hs1_c;
   logic w_hs2_c;

   // First half adder: a + b.
   assign w_hs1_s = a ^ b;
   assign w_hs1_c = a & b;

   // Second half adder: partial sum + cin.
   assign s       = w_hs1_s ^ cin;
   assign w_hs2_c = w_hs1_s & cin;

   // At most one of the two half-adder carries can be set.
   assign cout    = w_hs1_c | w_hs2_c;

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: computes {cout,sum} = a + b + cin one bit per clock,
// LSB first, through a single full_adder_cell. Operands are captured on an
// accepted start; the result appears with a one-cycle done pulse WIDTH+1
// cycles after the start edge and is held until the next accepted start.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN): adds input 'sub'. With sub=1
// the unit computes a - b (B inverted at load, carry loaded with 1); cout=1
// then means no borrow.
//
// Ports:
//   clk   (in)  : rising-edge clock
//   rst   (in)  : asynchronous active-high reset
//   start (in)  : operation request, accepted whenever busy=0
//   a, b  (in)  : WIDTH-bit operands, captured on accepted start
//   cin   (in)  : carry in, captured on accepted start
//   sub   (in)  : subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy  (out) : addition in progress
//   done  (out) : one-cycle pulse, sum/cout valid
//   sum   (out) : WIDTH-bit result
//   cout  (out) : final carry out
// ----------------------------------------------------------------------------
import arith_pkg::*;

module serial_adder #(
   parameter int WIDTH = ADDER_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   adder_state_t     r_state;
   adder_state_t     w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_accept;
   logic             w_last;
   logic             w_fa_s;
   logic             w_fa_co;
   logic [WIDTH-1:0] w_sum_shift;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   // A start is honoured in IDLE and in FIN, which lets a new operation
   // begin in the done cycle with no bubble.
   assign w_accept = start && (r_state != RUN);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: a + ~b + 1; cin is ignored when sub=1.
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub | cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   full_adder_cell u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .s    (w_fa_s),
      .cout (w_fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sum_shift = w_fa_s;
      end else begin : g_wn
         assign w_sum_shift = {w_fa_s, r_sum[WIDTH-1:1]};
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: outputs get defaults before the case so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = FIN;
         end
         FIN: begin
            done        = 1'b1;
            w_state_nxt = start ? RUN : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= w_b_load;
         r_carry <= w_c_load;
         r_cnt   <= '0;
         r_sum   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_fa_co;
         r_cnt   <= r_cnt + CNT_W'(1);
         r_sum   <= w_sum_shift;
         // The carry out of the final bit is the result's cout.
         if (w_last) r_cout <= w_fa_co;
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : serial_adder
